// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - single-port data RAM with valid/ready requests, byte enables, RD_LAT pipeline and clear-after-reset
// Optional word parity with error injection when DATA_RAM_PARITY_EN is defined.
module data_ram_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
`ifdef DATA_RAM_PARITY_EN
    input  logic                inj_perr,
`endif
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("data_ram_ctrl: DATA_W must be a multiple of 8");
    end
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("data_ram_ctrl: RD_LAT must be in 1..3");
    end
    if (DEPTH < 1 || DEPTH > 2 ** ADDR_W) begin : g_bad_depth
        $error("data_ram_ctrl: DEPTH must be in 1..2**ADDR_W");
    end

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rsp_d_n;
    logic              rsp_e_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_n;
            if (state == S_CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        init_done = 1'b0;
        case (state)
            S_CLEAR: begin
                if (clr_addr == LAST_IDX) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_n = S_CLEAR;
        endcase
    end

    // Full-width compare so addresses beyond DEPTH are flagged, never wrapped.
    assign accept   = req_valid && req_ready && !rst;
    assign in_range = {1'b0, req_addr} < DEPTH_X;
    assign idx      = req_addr[IDX_W-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;

    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (req_be[i]) begin
                merged[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (accept && req_we && in_range) begin
            mem[idx] <= merged;
        end
    end

`ifdef DATA_RAM_PARITY_EN
    logic par_mem [DEPTH];
    logic rd_par;
    logic perr;

    assign rd_par = in_range ? par_mem[idx] : 1'b0;
    assign perr   = in_range && ((^rd_word) != rd_par);

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            par_mem[clr_addr] <= 1'b0;
        end else if (accept && req_we && in_range) begin
            par_mem[idx] <= (^merged) ^ inj_perr;
        end
    end

    assign rsp_e_n = !in_range || (!req_we && perr);
`else
    assign rsp_e_n = !in_range;
`endif

    assign rsp_d_n = !in_range ? '0 : (req_we ? merged : rd_word);

    // Each stage's data only advances with a valid entry, so the last stage holds between responses.
    logic              pv [RD_LAT];
    logic [DATA_W-1:0] pd [RD_LAT];
    logic              pe [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
                pe[i] <= 1'b0;
            end
        end else begin
            pv[0] <= accept;
            if (accept) begin
                pd[0] <= rsp_d_n;
                pe[0] <= rsp_e_n;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                    pe[i] <= pe[i-1];
                end
            end
        end
    end

    assign rsp_valid = pv[RD_LAT-1];
    assign rsp_rdata = pd[RD_LAT-1];
    assign rsp_err   = pv[RD_LAT-1] & pe[RD_LAT-1];

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - table-driven bench for data_ram_ctrl; three instances share stimulus with RD_LAT 1, 2, 3
module tb_data_ram_ctrl;

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        inj;
        logic [15:0] exp_d;
        logic        exp_e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_be;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        inj_perr;
    logic        rr [3];
    logic        rv [3];
    logic [15:0] rd [3];
    logic        re [3];
    logic        id [3];

    int n_checks;
    int n_errors;

    int          got_n [3];
    int          got_c [3][2];
    logic [15:0] got_d [3][2];
    logic        got_e [3][2];
    int          idle_err;

    vec_t tab1 [17];
    vec_t tab2 [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        data_ram_ctrl #(
            .DATA_W(16),
            .ADDR_W(16),
            .DEPTH (256),
            .RD_LAT(k + 1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid),
            .req_ready(rr[k]),
            .req_we   (req_we),
            .req_be   (req_be),
            .req_addr (req_addr),
            .req_wdata(req_wdata),
`ifdef DATA_RAM_PARITY_EN
            .inj_perr (inj_perr),
`endif
            .rsp_valid(rv[k]),
            .rsp_rdata(rd[k]),
            .rsp_err  (re[k]),
            .init_done(id[k])
        );
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic we, input logic [1:0] be, input logic [15:0] addr,
                                input logic [15:0] wd, input logic inj, input logic [15:0] ed,
                                input logic ee);
        vec_t v;
        v.we = we; v.be = be; v.addr = addr; v.wdata = wd; v.inj = inj;
        v.exp_d = ed; v.exp_e = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid = 1'b1;
        req_we    = v.we;
        req_be    = v.be;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        inj_perr  = v.inj;
    endtask

    task automatic clear_got();
        idle_err = 0;
        for (int k = 0; k < 3; k++) got_n[k] = 0;
    endtask

    task automatic sample(input int c);
        for (int k = 0; k < 3; k++) begin
            if (rv[k]) begin
                if (got_n[k] < 2) begin
                    got_c[k][got_n[k]] = c;
                    got_d[k][got_n[k]] = rd[k];
                    got_e[k][got_n[k]] = re[k];
                end
                got_n[k]++;
            end else if (re[k]) begin
                idle_err++;
            end
        end
    endtask

    task automatic xact(input string nm, input vec_t v);
        check($sformatf("%s ready", nm), rr[0], 1);
        clear_got();
        drive(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            sample(c);
            if (c < 6) begin
                @(posedge clk); #1;
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s lat%0d count", nm, k + 1), got_n[k], 1);
            check($sformatf("%s lat%0d cycle", nm, k + 1), got_c[k][0], k + 1);
            check($sformatf("%s lat%0d rdata", nm, k + 1), got_d[k][0], v.exp_d);
            check($sformatf("%s lat%0d err", nm, k + 1), got_e[k][0], v.exp_e);
            check($sformatf("%s lat%0d hold", nm, k + 1), rd[k], v.exp_d);
        end
        check($sformatf("%s idle err", nm), idle_err, 0);
    endtask

    task automatic pair(input string nm, input vec_t a, input vec_t b);
        clear_got();
        drive(a);
        @(posedge clk); #1;
        sample(1);
        drive(b);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            sample(c);
            if (c < 7) begin
                @(posedge clk); #1;
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s lat%0d count", nm, k + 1), got_n[k], 2);
            check($sformatf("%s lat%0d first cycle", nm, k + 1), got_c[k][0], k + 1);
            check($sformatf("%s lat%0d second cycle", nm, k + 1), got_c[k][1], k + 2);
            check($sformatf("%s lat%0d first rdata", nm, k + 1), got_d[k][0], a.exp_d);
            check($sformatf("%s lat%0d second rdata", nm, k + 1), got_d[k][1], b.exp_d);
        end
    endtask

    task automatic clear_seq(input string nm);
        int n;
        int seen_v;
        int seen_id;
        n = 0; seen_v = 0; seen_id = 0;
        while (!rr[0] && n < 400) begin
            for (int k = 0; k < 3; k++) begin
                if (rv[k]) seen_v++;
                if (id[k] || rr[k]) seen_id++;
            end
            n++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check($sformatf("%s length", nm), n, 256);
        check($sformatf("%s rsp during clear", nm), seen_v, 0);
        check($sformatf("%s ready/done early", nm), seen_id, 0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s lat%0d init_done", nm, k + 1), id[k], 1);
            check($sformatf("%s lat%0d req_ready", nm, k + 1), rr[k], 1);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 2'b00;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        inj_perr  = 1'b0;

        tab1[0]  = mk(0, 2'b00, 16'd0,     16'h0000, 0, 16'h0000, 0);
        tab1[1]  = mk(0, 2'b00, 16'd128,   16'h0000, 0, 16'h0000, 0);
        tab1[2]  = mk(0, 2'b00, 16'd255,   16'h0000, 0, 16'h0000, 0);
        tab1[3]  = mk(0, 2'b00, 16'd2,     16'h0000, 0, 16'h0000, 0);
        tab1[4]  = mk(1, 2'b11, 16'd5,     16'hBEEF, 0, 16'hBEEF, 0);
        tab1[5]  = mk(0, 2'b00, 16'd5,     16'h0000, 0, 16'hBEEF, 0);
        tab1[6]  = mk(1, 2'b11, 16'd9,     16'h1234, 0, 16'h1234, 0);
        tab1[7]  = mk(1, 2'b01, 16'd9,     16'hABCD, 0, 16'h12CD, 0);
        tab1[8]  = mk(0, 2'b00, 16'd9,     16'h0000, 0, 16'h12CD, 0);
        tab1[9]  = mk(1, 2'b00, 16'd9,     16'hFFFF, 0, 16'h12CD, 0);
        tab1[10] = mk(0, 2'b00, 16'd9,     16'h0000, 0, 16'h12CD, 0);
        tab1[11] = mk(1, 2'b11, 16'd256,   16'hFFFF, 0, 16'h0000, 1);
        tab1[12] = mk(0, 2'b00, 16'd256,   16'h0000, 0, 16'h0000, 1);
        tab1[13] = mk(0, 2'b00, 16'd0,     16'h0000, 0, 16'h0000, 0);
        tab1[14] = mk(1, 2'b11, 16'hFFFF,  16'hFFFF, 0, 16'h0000, 1);
        tab1[15] = mk(0, 2'b00, 16'd255,   16'h0000, 0, 16'h0000, 0);
        tab1[16] = mk(1, 2'b11, 16'd6,     16'h0606, 0, 16'h0606, 0);

        tab2[0] = mk(0, 2'b00, 16'd5, 16'h0000, 0, 16'h0000, 0);
        tab2[1] = mk(0, 2'b00, 16'd9, 16'h0000, 0, 16'h0000, 0);
        tab2[2] = mk(0, 2'b00, 16'd7, 16'h0000, 0, 16'h0000, 0);

        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset lat%0d req_ready", k + 1), rr[k], 0);
            check($sformatf("reset lat%0d rsp_valid", k + 1), rv[k], 0);
            check($sformatf("reset lat%0d rsp_rdata", k + 1), rd[k], 0);
            check($sformatf("reset lat%0d rsp_err", k + 1), re[k], 0);
            check($sformatf("reset lat%0d init_done", k + 1), id[k], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // A write held during CLEAR must be ignored.
        drive(mk(1, 2'b11, 16'd2, 16'hDEAD, 0, 16'h0, 0));
        clear_seq("clear1");

        for (int i = 0; i < 17; i++) begin
            xact($sformatf("vec%0d", i), tab1[i]);
        end

        pair("b2b_rd5_rd6", mk(0, 2'b00, 16'd5, 16'h0, 0, 16'hBEEF, 0),
                            mk(0, 2'b00, 16'd6, 16'h0, 0, 16'h0606, 0));
        pair("wr7_then_rd7", mk(1, 2'b11, 16'd7, 16'h7777, 0, 16'h7777, 0),
                             mk(0, 2'b00, 16'd7, 16'h0, 0, 16'h7777, 0));

        drive(mk(0, 2'b00, 16'd5, 16'h0, 0, 16'h0, 0));
        @(posedge clk); #1;
        drive(mk(0, 2'b00, 16'd9, 16'h0, 0, 16'h0, 0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst lat%0d rsp_valid", k + 1), rv[k], 0);
            check($sformatf("midrst lat%0d init_done", k + 1), id[k], 0);
        end
        clear_seq("clear2");

        for (int i = 0; i < 3; i++) begin
            xact($sformatf("postrst%0d", i), tab2[i]);
        end

`ifdef DATA_RAM_PARITY_EN
        xact("par_wr_inj", mk(1, 2'b11, 16'd3, 16'h00FF, 1, 16'h00FF, 0));
        xact("par_rd_bad", mk(0, 2'b00, 16'd3, 16'h0000, 0, 16'h00FF, 1));
        xact("par_wr_ok",  mk(1, 2'b11, 16'd3, 16'h00FF, 0, 16'h00FF, 0));
        xact("par_rd_ok",  mk(0, 2'b00, 16'd3, 16'h0000, 0, 16'h00FF, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
